// File: rtl/psum_bank_buffer_pkg.sv
// Shared types for the partial-sum bank buffer: operating modes and the per-column
// psum packet carried on both the write and read sides.
package psum_bank_buffer_pkg;

    localparam int unsigned PSUM_DATA_SIZE  = 16;
    localparam int unsigned PSUM_NUM_FILTER = 4;
    localparam int unsigned FILTER_IDX_W    = $clog2(PSUM_NUM_FILTER);

    typedef enum logic [1:0] {
        MODE_NONE = 2'd0,
        MODE1     = 2'd1,
        MODE2     = 2'd2,
        MODE_RSVD = 2'd3
    } OP_MODE;

    typedef struct packed {
        logic                      valid;
        logic [FILTER_IDX_W-1:0]   filter_idx;
        logic [PSUM_DATA_SIZE-1:0] psum;
    } PSUM_PACKET;

endpackage

// File: rtl/psum_bank_buffer_fifo.sv
// Single-clock FIFO with synchronous clear; one instance per (column, filter) pair.
// A write into a full FIFO succeeds only when a pop happens on the same edge.
module psum_fifo #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count_q == (AW + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem[rd_ptr_q];
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/psum_bank_buffer.sv
// Partial-sum bank buffer: per-column banks of per-filter FIFOs, filled by PEs and drained
// round-robin across non-empty filters. Optional sticky overflow flag: PSUM_BUF_OVERFLOW_CHK_EN.
module psum_bank_buffer
    import psum_bank_buffer_pkg::*;
#(
    parameter int unsigned NUM_COL    = 7,
    parameter int unsigned NUM_FILTER = PSUM_NUM_FILTER,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_conv,
    input  OP_MODE                   mode_in,
    input  PSUM_PACKET [NUM_COL-1:0] psum_in,
    input  logic       [NUM_COL-1:0] pe_psum_ack,
    output logic       [NUM_COL-1:0] psum_buffer_ack,
    output PSUM_PACKET [NUM_COL-1:0] psum_out,
    output logic                     drain_done,
`ifdef PSUM_BUF_OVERFLOW_CHK_EN
    output logic                     overflow,
`endif
    output logic                     busy
);

    localparam int unsigned FW = FILTER_IDX_W;

    typedef enum logic [1:0] {StIdle, StFill, StDrain} state_e;

    state_e                    state_q, state_d;
    logic [FW-1:0]             rd_sel_q [NUM_COL];
    logic [FW-1:0]             rd_sel_d [NUM_COL];
    logic                      drain_done_q;
    logic                      drain_exit;

    logic                      full_w   [NUM_COL][NUM_FILTER];
    logic                      empty_w  [NUM_COL][NUM_FILTER];
    logic [PSUM_DATA_SIZE-1:0] head_w   [NUM_COL][NUM_FILTER];
    logic                      wr_en_w  [NUM_COL][NUM_FILTER];
    logic                      rd_en_w  [NUM_COL][NUM_FILTER];

    logic                      clear_all;
    logic                      start_drain;
    logic                      accept_wr;
    logic                      all_empty;

    logic [FW-1:0]             cur;
    logic [FW-1:0]             widx;
    logic [NUM_FILTER-1:0]     ne_col;
    logic                      out_valid;
    logic                      pop;
    logic                      wr_req;
    logic                      can_wr;
`ifdef PSUM_BUF_OVERFLOW_CHK_EN
    logic [NUM_COL-1:0]        drop_col;
    logic                      overflow_q;
`endif

    // First non-empty filter after cur in round-robin order; cur itself if there is none.
    function automatic logic [FW-1:0] next_nonempty(input logic [NUM_FILTER-1:0] ne,
                                                    input logic [FW-1:0]         cur_idx);
        logic [FW-1:0] res;
        logic [FW-1:0] cand;
        res = cur_idx;
        for (int k = int'(NUM_FILTER) - 1; k >= 1; k--) begin
            cand = cur_idx + FW'(k);
            if (ne[cand]) res = cand;
        end
        return res;
    endfunction

    assign clear_all   = start_conv && (mode_in == MODE1);
    assign start_drain = start_conv && (mode_in == MODE2);
    assign accept_wr   = (state_q != StIdle) && !clear_all;
    assign busy        = (state_q != StIdle);
    assign drain_done  = drain_done_q;

    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
        for (genvar f = 0; f < NUM_FILTER; f++) begin : g_filt
            psum_fifo #(
                .DEPTH (DEPTH),
                .WIDTH (PSUM_DATA_SIZE)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr     (clear_all),
                .wr_en   (wr_en_w[c][f]),
                .wr_data (psum_in[c].psum),
                .rd_en   (rd_en_w[c][f]),
                .full    (full_w[c][f]),
                .empty   (empty_w[c][f]),
                .head    (head_w[c][f])
            );
        end
    end

    always_comb begin
        psum_buffer_ack = '0;
        psum_out        = '0;
        wr_en_w         = '{default: '0};
        rd_en_w         = '{default: '0};
        rd_sel_d        = rd_sel_q;
        cur             = '0;
        widx            = '0;
        ne_col          = '0;
        out_valid       = 1'b0;
        pop             = 1'b0;
        wr_req          = 1'b0;
        can_wr          = 1'b0;
`ifdef PSUM_BUF_OVERFLOW_CHK_EN
        drop_col        = '0;
`endif
        for (int c = 0; c < NUM_COL; c++) begin
            cur = rd_sel_q[c];
            for (int f = 0; f < NUM_FILTER; f++) begin
                ne_col[f] = !empty_w[c][f];
            end
            out_valid = (state_q == StDrain) && ne_col[cur];
            pop       = out_valid && pe_psum_ack[c];

            // A full FIFO still takes a write when it is being popped on the same edge.
            widx   = psum_in[c].filter_idx;
            wr_req = accept_wr && psum_in[c].valid;
            can_wr = !full_w[c][widx] || (pop && (widx == cur));
            psum_buffer_ack[c] = wr_req && can_wr;
`ifdef PSUM_BUF_OVERFLOW_CHK_EN
            drop_col[c] = wr_req && !can_wr;
`endif
            for (int f = 0; f < NUM_FILTER; f++) begin
                wr_en_w[c][f] = psum_buffer_ack[c] && (widx == FW'(f));
                rd_en_w[c][f] = pop && (cur == FW'(f));
            end

            psum_out[c].valid      = out_valid;
            psum_out[c].filter_idx = cur;
            psum_out[c].psum       = out_valid ? head_w[c][cur] : '0;

            if (clear_all || start_drain) begin
                rd_sel_d[c] = '0;
            end else if ((state_q == StDrain) && (pop || !ne_col[cur])) begin
                rd_sel_d[c] = next_nonempty(ne_col, cur);
            end
        end
    end

    always_comb begin
        all_empty = 1'b1;
        for (int c = 0; c < NUM_COL; c++) begin
            for (int f = 0; f < NUM_FILTER; f++) begin
                if (!empty_w[c][f]) all_empty = 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        drain_exit = 1'b0;
        if (clear_all) begin
            state_d = StFill;
        end else if (start_drain) begin
            state_d = StDrain;
        end else if ((state_q == StDrain) && all_empty && !(|psum_buffer_ack)) begin
            state_d    = StIdle;
            drain_exit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            drain_done_q <= 1'b0;
            for (int c = 0; c < NUM_COL; c++) rd_sel_q[c] <= '0;
        end else begin
            state_q      <= state_d;
            drain_done_q <= drain_exit;
            for (int c = 0; c < NUM_COL; c++) rd_sel_q[c] <= rd_sel_d[c];
        end
    end

`ifdef PSUM_BUF_OVERFLOW_CHK_EN
    always_ff @(posedge clk) begin
        if (!rst_n || clear_all) begin
            overflow_q <= 1'b0;
        end else if (|drop_col) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_psum_bank_buffer.sv
// Directed bench for psum_bank_buffer: a vector table for the basic fill/drain flow and
// hand-written sequences for overflow, round-robin skip, full read/write, reset and abort.
module tb_psum_bank_buffer;
    import psum_bank_buffer_pkg::*;

    localparam int NC  = 7;
    localparam int DEP = 64;

    logic                clk;
    logic                rst_n;
    logic                start_conv;
    OP_MODE              mode_in;
    PSUM_PACKET [NC-1:0] psum_in;
    logic       [NC-1:0] pe_psum_ack;
    logic       [NC-1:0] psum_buffer_ack;
    PSUM_PACKET [NC-1:0] psum_out;
    logic                drain_done;
    logic                busy;
`ifdef PSUM_BUF_OVERFLOW_CHK_EN
    logic                overflow;
`endif

    int n_vec = 0;
    int n_err = 0;

    psum_bank_buffer #(
        .NUM_COL    (NC),
        .NUM_FILTER (4),
        .DEPTH      (DEP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_conv      (start_conv),
        .mode_in         (mode_in),
        .psum_in         (psum_in),
        .pe_psum_ack     (pe_psum_ack),
        .psum_buffer_ack (psum_buffer_ack),
        .psum_out        (psum_out),
        .drain_done      (drain_done),
`ifdef PSUM_BUF_OVERFLOW_CHK_EN
        .overflow        (overflow),
`endif
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    typedef struct {
        logic        rst;
        logic        start;
        OP_MODE      mode;
        logic        wv;
        logic [1:0]  wf;
        logic [15:0] wd;
        logic        pa;
        logic        e_ack;
        logic        e_v;
        logic [1:0]  e_f;
        logic [15:0] e_d;
        logic        e_busy;
        logic        e_done;
        string       name;
    } vec_t;

    function automatic vec_t mk(input logic st, input OP_MODE m, input logic wv,
                                input logic [1:0] wf, input logic [15:0] wd, input logic pa,
                                input logic ea, input logic ev, input logic [1:0] ef,
                                input logic [15:0] ed, input logic eb, input logic edn,
                                input string nm);
        vec_t v;
        v.rst = 1'b1; v.start = st; v.mode = m; v.wv = wv; v.wf = wf; v.wd = wd; v.pa = pa;
        v.e_ack = ea; v.e_v = ev; v.e_f = ef; v.e_d = ed; v.e_busy = eb; v.e_done = edn;
        v.name = nm;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic clr_in();
        start_conv  = 1'b0;
        mode_in     = MODE_NONE;
        psum_in     = '0;
        pe_psum_ack = '0;
    endtask

    // Advance to the next negedge with idle inputs; callers then drive and sample after #1.
    task automatic tick();
        @(negedge clk);
        clr_in();
    endtask

    task automatic wr(input int c, input int f, input int d);
        PSUM_PACKET p;
        p.valid      = 1'b1;
        p.filter_idx = f[FILTER_IDX_W-1:0];
        p.psum       = d[PSUM_DATA_SIZE-1:0];
        psum_in[c]   = p;
    endtask

    task automatic start(input OP_MODE m);
        start_conv = 1'b1;
        mode_in    = m;
    endtask

    vec_t        vecs[12];
    logic [17:0] got_q[$];
    logic [17:0] exp_q[$];
    logic [31:0] pk_got, pk_exp;
    int          n_ok, bad, seen_v;
    logic        done_seen;

    initial begin
        rst_n = 1'b0;
        clr_in();
        repeat (2) @(posedge clk);

        // Column 0: fill filter 2 with two entries, then drain them.
        vecs[0]  = mk(0, MODE_NONE, 0, 0, 16'h0,  0, 0, 0, 0, 16'h0,  0, 0, "reset_state");
        vecs[1]  = mk(0, MODE_NONE, 1, 2, 16'h55, 0, 0, 0, 0, 16'h0,  0, 0, "idle_write_rejected");
        vecs[2]  = mk(1, MODE1,     0, 0, 16'h0,  0, 0, 0, 0, 16'h0,  0, 0, "mode1_start");
        vecs[3]  = mk(0, MODE_NONE, 1, 2, 16'h11, 0, 1, 0, 0, 16'h0,  1, 0, "write_0x11");
        vecs[4]  = mk(0, MODE_NONE, 1, 2, 16'h22, 0, 1, 0, 0, 16'h0,  1, 0, "write_0x22");
        vecs[5]  = mk(1, MODE2,     0, 0, 16'h0,  0, 0, 0, 0, 16'h0,  1, 0, "mode2_start");
        vecs[6]  = mk(0, MODE_NONE, 0, 0, 16'h0,  1, 0, 0, 0, 16'h0,  1, 0, "skip_empty_f0");
        vecs[7]  = mk(0, MODE_NONE, 0, 0, 16'h0,  1, 0, 1, 2, 16'h11, 1, 0, "head_0x11");
        vecs[8]  = mk(0, MODE_NONE, 0, 0, 16'h0,  1, 0, 1, 2, 16'h22, 1, 0, "head_0x22");
        vecs[9]  = mk(0, MODE_NONE, 0, 0, 16'h0,  1, 0, 0, 0, 16'h0,  1, 0, "drain_all_empty");
        vecs[10] = mk(0, MODE_NONE, 0, 0, 16'h0,  0, 0, 0, 0, 16'h0,  0, 1, "drain_done_pulse");
        vecs[11] = mk(0, MODE_NONE, 0, 0, 16'h0,  0, 0, 0, 0, 16'h0,  0, 0, "drain_done_clear");

        for (int i = 0; i < 12; i++) begin
            tick();
            rst_n = vecs[i].rst;
            if (vecs[i].start) start(vecs[i].mode);
            if (vecs[i].wv) wr(0, int'(vecs[i].wf), int'(vecs[i].wd));
            pe_psum_ack[0] = vecs[i].pa;
            #1;
            pk_got = {10'd0, psum_buffer_ack[0], psum_out[0].valid,
                      psum_out[0].valid ? psum_out[0].filter_idx : 2'd0,
                      psum_out[0].valid ? psum_out[0].psum : 16'd0, busy, drain_done};
            pk_exp = {10'd0, vecs[i].e_ack, vecs[i].e_v, vecs[i].e_f, vecs[i].e_d,
                      vecs[i].e_busy, vecs[i].e_done};
            check(vecs[i].name, pk_got, pk_exp);
        end

        // Column 1: filter0 x1, filter3 x2; drain order must be 0,3,3.
        tick(); start(MODE1);
        tick(); wr(1, 0, 'hA0);
        tick(); wr(1, 3, 'hB0);
        tick(); wr(1, 3, 'hB1);
        tick(); start(MODE2);
        got_q.delete();
        done_seen = 1'b0;
        for (int i = 0; i < 10 && !done_seen; i++) begin
            tick();
            pe_psum_ack[1] = 1'b1;
            #1;
            if (psum_out[1].valid) got_q.push_back({psum_out[1].filter_idx, psum_out[1].psum});
            if (drain_done) done_seen = 1'b1;
        end
        exp_q = '{{2'd0, 16'hA0}, {2'd3, 16'hB0}, {2'd3, 16'hB1}};
        check("rr_count", got_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rr_entry%0d", i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF,
                  32'(exp_q[i]));
        end
        check("rr_drain_done", done_seen, 1);

        // Column 3 filter 1: fill to DEPTH, overflow, then full simultaneous write + pop.
        tick(); start(MODE1);
        n_ok = 0;
        for (int i = 0; i < DEP; i++) begin
            tick(); wr(3, 1, 'h100 + i);
            #1;
            if (psum_buffer_ack[3]) n_ok++;
        end
        check("fill_acks", n_ok, DEP);
        tick(); wr(3, 1, 'hDEAD);
        #1 check("full_drop_ack", psum_buffer_ack[3], 0);
`ifdef PSUM_BUF_OVERFLOW_CHK_EN
        tick();
        #1 check("overflow_set", overflow, 1);
`endif
        tick(); start(MODE2);
        tick();
        tick(); wr(3, 1, 'h999); pe_psum_ack[3] = 1'b1;
        #1;
        check("full_wr_pop_ack", psum_buffer_ack[3], 1);
        check("full_wr_pop_head", {psum_out[3].valid, psum_out[3].filter_idx, psum_out[3].psum},
              {1'b1, 2'd1, 16'h100});
        tick(); wr(3, 1, 'hAAA);
        #1 check("still_full_ack", psum_buffer_ack[3], 0);
        got_q.delete();
        done_seen = 1'b0;
        for (int i = 0; i < 200 && !done_seen; i++) begin
            tick();
            pe_psum_ack[3] = 1'b1;
            #1;
            if (psum_out[3].valid) got_q.push_back({psum_out[3].filter_idx, psum_out[3].psum});
            if (drain_done) done_seen = 1'b1;
        end
        check("full_drain_count", got_q.size(), DEP);
        bad = 0;
        for (int i = 0; i < DEP && i < got_q.size(); i++) begin
            if (got_q[i] !== ((i == DEP - 1) ? {2'd1, 16'h999} : {2'd1, 16'(32'h101 + i)})) bad++;
        end
        check("full_drain_order_errs", bad, 0);
        check("full_drain_done", done_seen, 1);

        // MODE1 during DRAIN aborts to FILL and clears everything.
        tick(); start(MODE1);
        tick(); wr(0, 0, 'h5);
        tick(); start(MODE2);
        tick();
        #1 check("abort_pre_head", {psum_out[0].valid, psum_out[0].psum}, {1'b1, 16'h5});
        tick(); start(MODE1);
        tick();
        #1 check("abort_state", {busy, psum_out[0].valid, drain_done}, {1'b1, 1'b0, 1'b0});
`ifdef PSUM_BUF_OVERFLOW_CHK_EN
        check("overflow_cleared_mode1", overflow, 0);
`endif
        tick(); start(MODE2);
        seen_v = 0;
        done_seen = 1'b0;
        for (int i = 0; i < 4 && !done_seen; i++) begin
            tick();
            #1;
            for (int c = 0; c < NC; c++) if (psum_out[c].valid) seen_v++;
            if (drain_done) done_seen = 1'b1;
        end
        check("abort_cleared_valids", seen_v, 0);
        check("abort_drain_done", done_seen, 1);

        // Reset mid-DRAIN, with a concurrent MODE1 start that reset must override.
        tick(); start(MODE1);
        tick(); wr(2, 0, 'h77);
        tick(); wr(2, 0, 'h78);
        tick(); start(MODE2);
        tick();
        #1 check("rst_pre_head", {psum_out[2].valid, psum_out[2].psum}, {1'b1, 16'h77});
        tick(); rst_n = 1'b0; start(MODE1);
        tick(); rst_n = 1'b1;
        #1;
        seen_v = 0;
        for (int c = 0; c < NC; c++) if (psum_out[c].valid) seen_v++;
        check("rst_busy", busy, 0);
        check("rst_valids", seen_v, 0);
`ifdef PSUM_BUF_OVERFLOW_CHK_EN
        check("rst_overflow", overflow, 0);
`endif
        start(MODE2);
        done_seen = 1'b0;
        for (int i = 0; i < 2 && !done_seen; i++) begin
            tick();
            #1;
            for (int c = 0; c < NC; c++) if (psum_out[c].valid) seen_v++;
            if (drain_done) done_seen = 1'b1;
        end
        check("rst_then_drain_done", done_seen, 1);
        check("rst_then_no_data", seen_v, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
